// File: rtl/ysyx_22040127_mem_stage.sv
// Memory-access pipeline stage between execute and writeback: one instruction at a time,
// at most one data-memory transaction, load extension and a registered result bus to writeback.
module ysyx_22040127_mem_stage #(
  parameter int PASS_W = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  ex_to_mem_valid,
  output logic                  mem_allowin,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic [1:0]            ex_mem_size,
  input  logic                  ex_mem_unsigned,
  input  logic [63:0]           ex_addr,
  input  logic [63:0]           ex_wdata,
  input  logic [63:0]           ex_alu_result,
  input  logic                  ex_reg_wen,
  input  logic [4:0]            ex_rd,
  input  logic [PASS_W-1:0]     ex_pass,

  output logic                  mem_to_wb_valid,
  input  logic                  wb_allowin,
  output logic [PASS_W+198:0]   mem_to_wb_bus,
  input  logic                  mem_flush,

  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic                  dmem_we,
  output logic [63:0]           dmem_addr,
  output logic [63:0]           dmem_wdata,
  output logic [7:0]            dmem_wmask,
  input  logic                  dmem_resp_valid,
  input  logic [63:0]           dmem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  function automatic logic [7:0] size_lanes(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic [63:0] size_mask64(input logic [1:0] size);
    logic [63:0] m;
    case (size)
      2'd0:    m = 64'h0000_0000_0000_00FF;
      2'd1:    m = 64'h0000_0000_0000_FFFF;
      2'd2:    m = 64'h0000_0000_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

  // Byte lanes shifted past lane 7 fall off the top: boundary-crossing accesses are truncated.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
    logic [15:0] m;
    m = {8'h00, size_lanes(size)} << off;
    return m[7:0];
  endfunction

  function automatic logic [63:0] load_extend(input logic [63:0] rdata, input logic [1:0] size,
                                              input logic [2:0] off, input logic uns);
    logic [63:0] sh;
    logic [63:0] res;
    sh = rdata >> {off, 3'b000};
    case (size)
      2'd0:    res = {{56{~uns & sh[7]}},  sh[7:0]};
      2'd1:    res = {{48{~uns & sh[15]}}, sh[15:0]};
      2'd2:    res = {{32{~uns & sh[31]}}, sh[31:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  state_e              state_q, state_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [63:0]         addr_q, addr_d;
  logic [63:0]         st_wdata_q, st_wdata_d;
  logic [7:0]          st_wmask_q, st_wmask_d;
  logic [63:0]         diff_data_q, diff_data_d;
  logic                reg_wen_q, reg_wen_d;
  logic [4:0]          rd_q, rd_d;
  logic [PASS_W-1:0]   pass_q, pass_d;
  logic [63:0]         reg_wdata_q, reg_wdata_d;
  logic                accept;

  // A flush in DONE kills the held result, so it also blocks a same-edge accept.
  assign mem_allowin = (state_q == S_IDLE) ||
                       ((state_q == S_DONE) && wb_allowin && !mem_flush);
  assign accept      = ex_to_mem_valid && mem_allowin;

  always_comb begin
    state_d     = state_q;
    read_d      = read_q;
    write_d     = write_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    st_wdata_d  = st_wdata_q;
    st_wmask_d  = st_wmask_q;
    diff_data_d = diff_data_q;
    reg_wen_d   = reg_wen_q;
    rd_d        = rd_q;
    pass_d      = pass_q;
    reg_wdata_d = reg_wdata_q;

    unique case (state_q)
      S_IDLE: ;
      S_REQ: begin
        // Once the request is handshaked the memory owes a response, even if flushed.
        if (dmem_req_ready)  state_d = mem_flush ? S_DRAIN : S_WAIT;
        else if (mem_flush)  state_d = S_IDLE;
      end
      S_WAIT: begin
        if (dmem_resp_valid) begin
          state_d = mem_flush ? S_IDLE : S_DONE;
          if (read_q) reg_wdata_d = load_extend(dmem_rdata, size_q, addr_q[2:0], uns_q);
        end else if (mem_flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        if (mem_flush || wb_allowin) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (dmem_resp_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      state_d     = (ex_mem_read || ex_mem_write) ? S_REQ : S_DONE;
      read_d      = ex_mem_read;
      write_d     = ex_mem_write;
      size_d      = ex_mem_size;
      uns_d       = ex_mem_unsigned;
      addr_d      = ex_addr;
      st_wdata_d  = ex_wdata << {ex_addr[2:0], 3'b000};
      st_wmask_d  = lane_mask(ex_mem_size, ex_addr[2:0]);
      diff_data_d = ex_mem_write ? (ex_wdata & size_mask64(ex_mem_size)) : 64'd0;
      reg_wen_d   = ex_reg_wen;
      rd_d        = ex_rd;
      pass_d      = ex_pass;
      reg_wdata_d = ex_alu_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      addr_q      <= 64'd0;
      st_wdata_q  <= 64'd0;
      st_wmask_q  <= 8'd0;
      diff_data_q <= 64'd0;
      reg_wen_q   <= 1'b0;
      rd_q        <= 5'd0;
      pass_q      <= '0;
      reg_wdata_q <= 64'd0;
    end else begin
      state_q     <= state_d;
      read_q      <= read_d;
      write_q     <= write_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      st_wdata_q  <= st_wdata_d;
      st_wmask_q  <= st_wmask_d;
      diff_data_q <= diff_data_d;
      reg_wen_q   <= reg_wen_d;
      rd_q        <= rd_d;
      pass_q      <= pass_d;
      reg_wdata_q <= reg_wdata_d;
    end
  end

  assign mem_to_wb_valid = (state_q == S_DONE) && !mem_flush;
  assign mem_to_wb_bus   = {pass_q, write_q, diff_data_q, addr_q, reg_wen_q, rd_q, reg_wdata_q};

  assign dmem_req_valid  = (state_q == S_REQ);
  assign dmem_we         = write_q;
  assign dmem_addr       = {addr_q[63:3], 3'b000};
  assign dmem_wdata      = st_wdata_q;
  assign dmem_wmask      = st_wmask_q;

endmodule
